mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_C, default 4, number of cores sharing one DRAM port.
REQ-002 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, reset; synchronous and active-high.
REQ-004 Port req_valid, input, NUM_C, per-core request pending.
REQ-005 Port req_we, input, NUM_C, per-core request type: 1 = write, 0 = read.
REQ-006 Port req_addr, input, NUM_C*16, per-core word address; core i uses bits [i*16 +:16].
REQ-007 Port req_wdata, input, NUM_C*16, per-core write data, same packing.
REQ-008 Port ack, output, NUM_C, per-core one-cycle completion pulse.
REQ-009 Port rdata, output, NUM_C*16, per-core registered read data, same packing.
REQ-010 Port mem_we, output, 1, DRAM write enable.
REQ-011 Port mem_addr, output, 16, DRAM address.
REQ-012 Port mem_wdata, output, 16, DRAM write data.
REQ-013 Port mem_rdata, input, 16, DRAM registered read data, valid one cycle after the address is presented.
REQ-014 Port busy, output, 1, high in every state except IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-016 IDLE with any req_valid bit set SHALL grant exactly one core, latch its index, we, addr and wdata, and move to ISSUE; with no request it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: search from pointer p upward with wrap at NUM_C, take the first set bit, then set p = (granted+1) mod NUM_C.
REQ-018 Requests from non-granted cores SHALL be ignored, not queued; those cores keep req_valid high.
REQ-019 ISSUE SHALL drive the latched mem_addr and mem_wdata, assert mem_we for exactly this one cycle if the latched we = 1, then move to WAIT.
REQ-020 mem_we SHALL be 0 in every state other than ISSUE; mem_addr and mem_wdata SHALL hold their last values outside ISSUE.
REQ-021 WAIT SHALL, for a read, capture mem_rdata into rdata slice of the granted core, then move to DONE; for a write, rdata SHALL be unchanged.
REQ-022 DONE SHALL pulse ack for the granted core only, for exactly one cycle, then return to IDLE.
REQ-023 Latency: a request granted in IDLE cycle T SHALL give ISSUE at T+1, WAIT at T+2, ack at T+3, and the earliest next grant at T+4.
REQ-024 Cores SHALL hold req_valid and the request fields until ack and drop req_valid at the edge ending the ack cycle; the block SHALL re-arbitrate only in IDLE.
REQ-025 rdata slices SHALL be registers that keep their value until the next read completes for that core.
REQ-026 Addresses SHALL be passed unmodified, with no range check and no wrap.

Reset
REQ-027 With rst high at a rising edge, the block SHALL enter IDLE with p = 0, ack = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0 and busy = 0.
REQ-028 Reset in ISSUE, WAIT or DONE SHALL abort the transaction: no ack, and mem_we = 0 from the next cycle.
REQ-029 On the first cycle after rst falls, the block SHALL be able to grant a request.

Verification
REQ-030 Core 2 write addr 0x0010 data 0xBEEF -> mem_we = 1 with mem_addr = 0x0010 and mem_wdata = 0xBEEF for exactly one cycle at T+1; ack[2] at T+3; rdata unchanged.
REQ-031 Core 1 read addr 0x0010 with mem_rdata = 0xBEEF during WAIT -> rdata[31:16] = 0xBEEF and ack[1] pulse at T+3.
REQ-032 All four cores request continuously after reset -> grants in order 0,1,2,3,0 at 4-cycle spacing; each ack lasts one cycle.
REQ-033 Cores 1 and 3 request with p = 2 -> core 3 is granted first, then core 1.
REQ-034 rst asserted in WAIT of a core-0 read -> no ack[0], busy = 0 next cycle, p = 0, rdata = 0.
REQ-035 Idle for 10 cycles with no requests -> busy = 0, mem_we = 0 and ack = 0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter that shares a single DRAM port among
//               NUM_C cores. Each transaction goes through four states:
//               IDLE -> ISSUE -> WAIT -> DONE. Only one request is in flight
//               at a time.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req_valid/req_we    - per-core request strobe and type (1=wr)
//               req_addr/req_wdata  - per-core 16-bit fields, core i at [i*16 +:16]
//               ack                 - per-core one-cycle completion pulse
//               rdata               - per-core registered read data
//               mem_we/mem_addr/mem_wdata/mem_rdata - DRAM port
//               busy                - high whenever the FSM is not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NUM_C = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_C-1:0]     req_valid,
    input  logic [NUM_C-1:0]     req_we,
    input  logic [NUM_C*16-1:0]  req_addr,
    input  logic [NUM_C*16-1:0]  req_wdata,
    output logic [NUM_C-1:0]     ack,
    output logic [NUM_C*16-1:0]  rdata,
    output logic                 mem_we,
    output logic [15:0]          mem_addr,
    output logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata,
    output logic                 busy
);

    localparam int IDX_W = (NUM_C > 1) ? $clog2(NUM_C) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q,   ptr_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic                we_q,    we_d;
    logic [15:0]         addr_q,  addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [NUM_C*16-1:0] rdata_q, rdata_d;

    // Round-robin search results
    logic                gnt_found;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W:0]      cand;
    logic [IDX_W-1:0]    ptr_next;

    // ------------------------------------------------------------------
    // Round-robin search: walk from ptr_q upward, wrapping at NUM_C, and
    // take the first pending request. cand is one bit wider than an index
    // so ptr + k never overflows before the wrap is applied.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_C; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_C)) begin
                cand = cand - (IDX_W+1)'(NUM_C);
            end
            if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
        ptr_next = (gnt_idx == IDX_W'(NUM_C-1)) ? '0 : gnt_idx + 1'b1;
    end

    // ------------------------------------------------------------------
    // State register and datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    // Latching the address/data straight into the flops that
                    // feed the DRAM port means they appear in ISSUE and then
                    // simply hold until the next grant.
                    idx_d   = gnt_idx;
                    we_d    = req_we[gnt_idx];
                    addr_d  = req_addr[gnt_idx*16 +: 16];
                    wdata_d = req_wdata[gnt_idx*16 +: 16];
                    ptr_d   = ptr_next;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // DRAM read data is registered: valid the cycle after ISSUE.
                if (!we_q) begin
                    rdata_d[idx_q*16 +: 16] = mem_rdata;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ack       = '0;
        mem_we    = (state_q == S_ISSUE) && we_q;
        busy      = (state_q != S_IDLE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rdata     = rdata_q;
        if (state_q == S_DONE) begin
            ack[idx_q] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter. Stimulus pushes expected
//               DRAM writes and acks (with cycle stamps) into a queue; a
//               monitor pops and compares on every mem_we / ack cycle.
//               A small registered DRAM model answers reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int NUM_C = 4;

    logic                clk;
    logic                rst;
    logic [NUM_C-1:0]    req_valid;
    logic [NUM_C-1:0]    req_we;
    logic [NUM_C*16-1:0] req_addr;
    logic [NUM_C*16-1:0] req_wdata;
    logic [NUM_C-1:0]    ack;
    logic [NUM_C*16-1:0] rdata;
    logic                mem_we;
    logic [15:0]         mem_addr;
    logic [15:0]         mem_wdata;
    logic [15:0]         mem_rdata;
    logic                busy;

    mem_arbiter #(.NUM_C(NUM_C)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_ack;
        int          core;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   auto_drop = 1'b1;

    logic [15:0] dram [0:255];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Registered DRAM model: sample the port mid-cycle, answer after the edge.
    initial begin
        logic [7:0] a;
        a = '0;
        mem_rdata = '0;
        for (int k = 0; k < 256; k++) dram[k] = 16'h5000 + 16'(k);
        forever begin
            @(negedge clk);
            a = mem_addr[7:0];
            if (mem_we === 1'b1) dram[mem_addr[7:0]] = mem_wdata;
            @(posedge clk);
            #1;
            mem_rdata = dram[a];
        end
    end

    // Core model: drop req_valid at the edge that ends the ack cycle.
    initial begin
        logic [NUM_C-1:0] a;
        forever begin
            @(negedge clk);
            a = ack;
            @(posedge clk);
            #1;
            if (auto_drop) begin
                for (int i = 0; i < NUM_C; i++) if (a[i] === 1'b1) req_valid[i] = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        exp_t             e;
        logic [NUM_C-1:0] oh;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_mem_we: cyc=%0d addr=0x%04h data=0x%04h, required no write", cyc, mem_addr, mem_wdata);
                end else begin
                    e = sbq.pop_front();
                    if (e.is_ack || mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL mem_write: got cyc=%0d addr=0x%04h data=0x%04h, required is_ack=%0d cyc=%0d addr=0x%04h data=0x%04h",
                                 cyc, mem_addr, mem_wdata, e.is_ack, e.cyc, e.addr, e.data);
                    end
                end
            end
            if (ack !== '0) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack: cyc=%0d ack=%b, required none", cyc, ack);
                end else begin
                    e = sbq.pop_front();
                    oh = '0;
                    oh[e.core] = 1'b1;
                    if (!e.is_ack || ack !== oh || rdata[e.core*16 +: 16] !== e.data || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL ack: got cyc=%0d ack=%b rdata=0x%016h, required cyc=%0d ack=%b slice%0d=0x%04h",
                                 cyc, ack, rdata, e.cyc, oh, e.core, e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic req(input int c, input bit we, input logic [15:0] a, input logic [15:0] d);
        req_we[c]             = we;
        req_addr[c*16 +: 16]  = a;
        req_wdata[c*16 +: 16] = d;
        req_valid[c]          = 1'b1;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d, input int cy);
        exp_t e;
        e.is_ack = 1'b0; e.core = 0; e.addr = a; e.data = d; e.cyc = cy;
        sbq.push_back(e);
    endtask

    task automatic push_ack(input int c, input logic [15:0] d, input int cy);
        exp_t e;
        e.is_ack = 1'b1; e.core = c; e.addr = '0; e.data = d; e.cyc = cy;
        sbq.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy !== 1'b0) && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d expectations left, busy=%b after %0d cycles", sbq.size(), busy, n);
            sbq.delete();
        end
        step();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},   64'(busy),      64'h0);
        chk({tag, "_ack"},    64'(ack),       64'h0);
        chk({tag, "_mem_we"}, 64'(mem_we),    64'h0);
        chk({tag, "_maddr"},  64'(mem_addr),  64'h0);
        chk({tag, "_mwdata"}, 64'(mem_wdata), 64'h0);
        chk({tag, "_rdata"},  64'(rdata),     64'h0);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;

        // Core 2 write 0x0010 <= 0xBEEF
        t = cyc;
        req(2, 1'b1, 16'h0010, 16'hBEEF);
        push_wr(16'h0010, 16'hBEEF, t + 1);
        push_ack(2, 16'h0000, t + 3);
        drain(20);
        chk("hold_maddr",  64'(mem_addr),  64'h0010);
        chk("hold_mwdata", 64'(mem_wdata), 64'hBEEF);
        chk("wr_rdata_unchanged", 64'(rdata), 64'h0);

        // Core 1 read 0x0010 -> 0xBEEF
        t = cyc;
        req(1, 1'b0, 16'h0010, 16'h0000);
        push_ack(1, 16'hBEEF, t + 3);
        drain(20);
        chk("rd_slice1", 64'(rdata[31:16]), 64'hBEEF);

        // Pointer now 2: cores 1 and 3 pending -> 3 first, then 1
        t = cyc;
        req(3, 1'b0, 16'h0020, 16'h0000);
        req(1, 1'b1, 16'h0030, 16'h1234);
        push_ack(3, 16'h5020, t + 3);
        push_wr(16'h0030, 16'h1234, t + 5);
        push_ack(1, 16'hBEEF, t + 7);
        drain(40);

        // All four continuously after reset -> 0,1,2,3,0 at 4-cycle spacing
        rst = 1'b1;
        step();
        chk_reset_state("reset2");
        rst = 1'b0;
        auto_drop = 1'b0;
        t = cyc;
        for (int i = 0; i < NUM_C; i++) req(i, 1'b0, 16'h0040 + 16'(i), 16'h0000);
        push_ack(0, 16'h5040, t + 3);
        push_ack(1, 16'h5041, t + 7);
        push_ack(2, 16'h5042, t + 11);
        push_ack(3, 16'h5043, t + 15);
        push_ack(0, 16'h5040, t + 19);
        while (cyc < t + 20) step();
        req_valid = '0;
        auto_drop = 1'b1;
        drain(20);

        // Reset during WAIT of a core-0 read (pointer was 1 beforehand)
        t = cyc;
        req(0, 1'b0, 16'h0050, 16'h0000);
        while (cyc < t + 2) step();
        chk("wait_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        req_valid[0] = 1'b0;
        step();
        rst = 1'b0;
        chk("abort_busy",   64'(busy),   64'h0);
        chk("abort_ack",    64'(ack),    64'h0);
        chk("abort_mem_we", 64'(mem_we), 64'h0);
        chk("abort_rdata",  64'(rdata),  64'h0);
        // First cycle after reset: grant must be possible and start from core 0
        t = cyc;
        req(0, 1'b0, 16'h0050, 16'h0000);
        req(1, 1'b0, 16'h0051, 16'h0000);
        push_ack(0, 16'h5050, t + 3);
        push_ack(1, 16'h5051, t + 7);
        drain(40);

        // Quiet for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy",   64'(busy),   64'h0);
            chk("idle_mem_we", 64'(mem_we), 64'h0);
            chk("idle_ack",    64'(ack),    64'h0);
        end

        chk("sb_empty", 64'(sbq.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
